alu_exec: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit ALU control code from the ALU control stage plus two 32-bit operands, and produces the result, zero and overflow flags for the writeback/branch logic. Single-cycle ops finish in one cycle. Shifts iterate one bit per cycle unless the fast shifter is compiled in. Valid/ready handshakes on both sides let the controller stall cleanly.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_shift_unit.sv | 57 +++++
 rtl/alu_exec.sv | 141 ++++++++++++++
 tb/tb_alu_exec.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and execute-unit state shared by the ALU control stage and alu_exec.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_EQ      = 4'd3;
  localparam logic [3:0] ALU_GT      = 4'd4;
  localparam logic [3:0] ALU_GE      = 4'd5;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_NE      = 4'd8;
  localparam logic [3:0] ALU_SLL     = 4'd10;
  localparam logic [3:0] ALU_SRL     = 4'd11;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operation-in / result-out valid/ready handshake of the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: logical SLL/SRL path; one bit per cycle, or a barrel shifter when
// ALU_FAST_SHIFT_EN is defined (then done follows start and nothing is registered).
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

`ifdef ALU_FAST_SHIFT_EN
  assign result = (code == ALU_SRL) ? (value >> amount) : (value << amount);
  assign busy   = 1'b0;
  assign done   = start;
`else
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [SHW-1:0]   cnt_reg;
  logic             right_reg;
  logic             busy_reg;

  assign work_next = right_reg ? {1'b0, work_reg[WIDTH-1:1]} : {work_reg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg  <= '0;
      cnt_reg   <= '0;
      right_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (busy_reg) begin
      work_reg <= work_next;
      cnt_reg  <= cnt_reg - 1'b1;
      if (cnt_reg == SHW'(1)) busy_reg <= 1'b0;
    end else if (start && (amount != '0)) begin
      work_reg  <= value;
      cnt_reg   <= amount;
      right_reg <= (code == ALU_SRL);
      busy_reg  <= 1'b1;
    end
  end

  // result is the value after this cycle's shift, so the final step can be captured directly
  assign result = work_next;
  assign busy   = busy_reg;
  assign done   = busy_reg && (cnt_reg == SHW'(1));
`endif

endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU execute stage with valid/ready on both sides.
// Define ALU_FAST_SHIFT_EN to replace iterative shifts with a single-cycle barrel shifter.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  alu_state_t       state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             overflow_reg;
  logic             illegal_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_val;
  logic             alu_ovf;
  logic             alu_ill;
  logic             accept;
  logic             shift_start;
  logic             shift_busy;
  logic             shift_done;
  logic [WIDTH-1:0] shift_res;

  assign accept = (state_reg == ST_IDLE) && bus.in_valid;
  assign sum    = bus.op_a + bus.op_b;
  assign diff   = bus.op_a - bus.op_b;

`ifdef ALU_FAST_SHIFT_EN
  assign shift_start = accept && is_shift(bus.alu_ctrl);
`else
  assign shift_start = accept && is_shift(bus.alu_ctrl) && (bus.op_b[SHW-1:0] != '0);
`endif

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (shift_start),
    .code   (bus.alu_ctrl),
    .value  (bus.op_a),
    .amount (bus.op_b[SHW-1:0]),
    .busy   (shift_busy),
    .done   (shift_done),
    .result (shift_res)
  );

  always_comb begin
    alu_val = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: alu_val = bus.op_a & bus.op_b;
      ALU_OR:  alu_val = bus.op_a | bus.op_b;
      ALU_ADD: begin
        alu_val = sum;
        alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_val = diff;
        alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      ALU_SLT: alu_val = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_EQ:  alu_val = WIDTH'(bus.op_a == bus.op_b);
      ALU_NE:  alu_val = WIDTH'(bus.op_a != bus.op_b);
      ALU_GT:  alu_val = WIDTH'($signed(bus.op_a) > $signed(bus.op_b));
      ALU_GE:  alu_val = WIDTH'($signed(bus.op_a) >= $signed(bus.op_b));
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL: alu_val = shift_res;
`else
      // only reached with a zero shift amount; non-zero amounts go through ST_SHIFT
      ALU_SLL, ALU_SRL: alu_val = bus.op_a;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (shift_start) begin
              state_reg <= ST_SHIFT;
            end else
`endif
            begin
              result_reg    <= alu_val;
              zero_reg      <= (alu_val == '0);
              overflow_reg  <= alu_ovf;
              illegal_reg   <= alu_ill;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        ST_SHIFT: begin
          if (shift_done) begin
            result_reg    <= shift_res;
            zero_reg      <= (shift_res == '0);
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE) && !shift_busy;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vector table, handshake/reset sequences and random ops against a reference model.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_exec_if #(.WIDTH(WIDTH)) bus();

  alu_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        il;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if (c == ALU_SLL || c == ALU_SRL) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // Reference model: signed values widened to 64 bits, overflow = out of 32-bit signed range
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output logic il);
    longint sa, sb, s;
    int amt;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b[4:0]);
    s   = 0;
    r   = 32'd0;
    o   = 1'b0;
    il  = 1'b0;
    case (c)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        s = sa + sb;
        r = s[31:0];
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        s = sa - sb;
        r = s[31:0];
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_EQ:  r = (sa == sb) ? 32'd1 : 32'd0;
      ALU_NE:  r = (sa != sb) ? 32'd1 : 32'd0;
      ALU_GT:  r = (sa > sb) ? 32'd1 : 32'd0;
      ALU_GE:  r = (sa >= sb) ? 32'd1 : 32'd0;
      ALU_SLL: begin
        s = longint'(a) * (64'sd1 <<< amt);
        r = s[31:0];
      end
      ALU_SRL: r = 32'(longint'(a) / (64'sd1 <<< amt));
      default: il = 1'b1;
    endcase
  endfunction

  // Called and returns just after a falling edge.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic eo, input logic ei);
    int waited;
    int lat;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(c, b)));
    check({tag, " result"}, bus.result, er);
    check({tag, " zero"}, 32'(bus.zero), 32'(ez));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
    check({tag, " illegal"}, 32'(bus.illegal), 32'(ei));
    $display("[TB] %s ctrl=%0d a=%h b=%h -> result=%h z=%b o=%b ill=%b lat=%0d",
             tag, c, a, b, bus.result, bus.zero, bus.overflow, bus.illegal, lat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " result"}, bus.result, 32'd0);
    check({tag, " zero"}, 32'(bus.zero), 32'd0);
    check({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, " illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb, rr;
    logic        ro, ril;

    vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ALU_GE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{ALU_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd12,   32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ALU_OR,  32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{ALU_EQ,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{ALU_NE,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{ALU_GT,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{ALU_SLL, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{ALU_SRL, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{ALU_INVALID, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].r, vecs[i].z, vecs[i].o, vecs[i].il);
    end

    // Backpressure: result holds in DONE and a pending offer waits for the handoff
    bus.alu_ctrl = ALU_ADD;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd4;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("stall first out_valid", 32'(bus.out_valid), 32'd1);
    bus.alu_ctrl = ALU_SUB;
    bus.op_a     = 32'd10;
    bus.op_b     = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d result", k), bus.result, 32'd7);
      check($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("handoff in_ready", 32'(bus.in_ready), 32'd1);
    check("handoff out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("held op out_valid", 32'(bus.out_valid), 32'd1);
    check("held op result", bus.result, 32'd6);
    $display("[TB] stall sequence: held op result=%h", bus.result);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while a long shift is in flight discards it
    bus.alu_ctrl = ALU_SRL;
    bus.op_a     = 32'h80000000;
    bus.op_b     = 32'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midshift reset");
    repeat (25) @(negedge clk);
    check("discarded out_valid", 32'(bus.out_valid), 32'd0);
    $display("[TB] reset sequence: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    run_op("post reset", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      model(rc, ra, rb, rr, ro, ril);
      run_op($sformatf("rand%0d", n), rc, ra, rb, rr, (rr == 32'd0), ro, ril);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
